// File: rtl/bin_to_bcd_display_if.sv
// bin_to_bcd_display_if
//   Groups the conversion request and result signals of bin_to_bcd_display.
//   master : drives Load/Value, observes the result (the upstream controller).
//   slave  : the converter itself.
//   Load     - conversion request
//   Value    - unsigned binary operand, BIN_WIDTH bits
//   Data     - packed BCD result, DIGITS nibbles, digit 0 in [3:0]
//   Busy     - conversion in progress
//   Done     - one-cycle pulse when Data has just been updated
//   Overflow - last accepted Value exceeded the displayable range
interface bin_to_bcd_display_if #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
);
  logic                  Load;
  logic [BIN_WIDTH-1:0]  Value;
  logic [4*DIGITS-1:0]   Data;
  logic                  Busy;
  logic                  Done;
  logic                  Overflow;

  modport master (
    output Load, Value,
    input  Data, Busy, Done, Overflow
  );

  modport slave (
    input  Load, Value,
    output Data, Busy, Done, Overflow
  );
endinterface

// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display
//   Iterative double-dabble (shift-add-3) binary to packed BCD converter that
//   feeds the seven-segment display driver. Values above 10^DIGITS-1 are
//   clamped to all nines and flagged with Overflow. The result register only
//   changes on the completion edge or on reset, so the display never sees an
//   intermediate value.
// Ports:
//   Clock  - system clock, rising edge
//   nReset - synchronous active-low reset
//   bus    - bin_to_bcd_display_if slave modport (Load, Value, Data, Busy,
//            Done, Overflow)
module bin_to_bcd_display #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input logic                 Clock,
  input logic                 nReset,
  bin_to_bcd_display_if.slave bus
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]          LIMIT     = pow10(DIGITS) - 64'd1;
  // Only used when the input exceeds LIMIT, which implies LIMIT fits in BIN_WIDTH.
  localparam logic [BIN_WIDTH-1:0] LIMIT_BIN = BIN_WIDTH'(LIMIT);
  localparam int                   CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0]     LAST      = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [0:0] {IDLE, CONVERT} state_t;

  state_t                state;
  logic [BIN_WIDTH-1:0]  shreg;
  logic [4*DIGITS-1:0]   acc;
  logic [4*DIGITS-1:0]   corrected;
  logic [4*DIGITS-1:0]   acc_next;
  logic [CNT_W-1:0]      count;
  logic [4*DIGITS-1:0]   data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  over;

  assign over = 64'(bus.Value) > LIMIT;

  // One double-dabble step: every nibble >= 5 is bumped by 3 from its
  // pre-correction value, then the operand MSB shifts into the accumulator.
  always_comb begin
    corrected = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) corrected[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {corrected[4*DIGITS-2:0], shreg[BIN_WIDTH-1]};
  end

  // Control FSM with registered outputs; Busy mirrors state == CONVERT.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state  <= IDLE;
      shreg  <= '0;
      acc    <= '0;
      count  <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Load) begin
            shreg  <= over ? LIMIT_BIN : bus.Value;
            acc    <= '0;
            ovf_q  <= over;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          acc   <= acc_next;
          shreg <= {shreg[BIN_WIDTH-2:0], 1'b0};
          count <= count + 1'b1;
          if (count == LAST) begin
            data_q <= acc_next;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Data     = data_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Overflow = ovf_q;

endmodule
